// File: rtl/param_cache_if.sv
// Bundles the CPU-side request/response and memory-side line-transfer signals of param_cache.
// The cache takes the slave view. The CPU/memory environment takes the master view.
interface param_cache_if;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable_cpu;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata_cpu;
    logic         mem_resp;
    logic [31:0]  mem_rdata_cpu;
    logic         d_miss;

    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable_cpu, mem_address, mem_wdata_cpu,
        input  pmem_resp, pmem_rdata,
        output mem_resp, mem_rdata_cpu, d_miss,
        output pmem_address, pmem_wdata, pmem_read, pmem_write
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable_cpu, mem_address, mem_wdata_cpu,
        output pmem_resp, pmem_rdata,
        input  mem_resp, mem_rdata_cpu, d_miss,
        input  pmem_address, pmem_wdata, pmem_read, pmem_write
    );
endinterface

// File: rtl/param_cache.sv
// Write-back, write-allocate, WAYS-way set-associative cache with 256-bit lines and tree-PLRU.
// Hits complete in the same cycle. Misses optionally write back the victim, then fill the line.
module param_cache #(
    parameter int S_INDEX = 3,
    parameter int WAYS    = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    param_cache_if.slave     bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;
    localparam int LVL   = $clog2(WAYS);
    localparam int WIDX  = (WAYS > 1) ? LVL : 1;
    localparam int PL_W  = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} state_t;

    logic [255:0]     data_arr  [SETS][WAYS];
    logic [TAG_W-1:0] tag_arr   [SETS][WAYS];
    logic [WAYS-1:0]  valid_arr [SETS];
    logic [WAYS-1:0]  dirty_arr [SETS];
    logic [PL_W-1:0]  plru_arr  [SETS];

    state_t           state;
    logic [S_INDEX-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic [WIDX-1:0]  miss_way;

    logic [S_INDEX-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [2:0]       word;
    logic             req;
    logic             hit_any;
    logic             inv_any;
    logic [WIDX-1:0]  hit_way;
    logic [WIDX-1:0]  inv_way;
    logic [WIDX-1:0]  victim;
    logic [255:0]     hit_line;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; a 0 bit points the victim search left.
    function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] p, input int way);
        logic [PL_W-1:0] r;
        int node;
        int b;
        r = p;
        node = 0;
        for (int l = 0; l < LVL; l++) begin
            b = (way >> (LVL - 1 - l)) & 1;
            r[node] = (b == 0);
            node = 2 * node + 1 + b;
        end
        return r;
    endfunction

    function automatic logic [WIDX-1:0] plru_victim(input logic [PL_W-1:0] p);
        int node;
        int v;
        node = 0;
        v = 0;
        for (int l = 0; l < LVL; l++) begin
            v = 2 * v + int'(p[node]);
            node = 2 * node + 1 + int'(p[node]);
        end
        return WIDX'(v);
    endfunction

    function automatic logic [255:0] merge_word(input logic [255:0] line, input logic [2:0] w,
                                                input logic [3:0] be, input logic [31:0] d);
        logic [255:0] r;
        r = line;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[{w, 5'b00000} + 8 * b +: 8] = d[8 * b +: 8];
        return r;
    endfunction

    assign idx  = bus.mem_address[5+S_INDEX-1:5];
    assign tag  = bus.mem_address[31:5+S_INDEX];
    assign word = bus.mem_address[4:2];
    assign req  = bus.mem_read | bus.mem_write;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it holding a value, which would infer a latch.
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_arr[idx][w] && tag_arr[idx][w] == tag) begin
                hit_any = 1'b1;
                hit_way = WIDX'(w);
            end
            if (!valid_arr[idx][w]) begin
                inv_any = 1'b1;
                inv_way = WIDX'(w);
            end
        end
        victim   = inv_any ? inv_way : plru_victim(plru_arr[idx]);
        hit_line = data_arr[idx][hit_way];
    end

    assign bus.mem_resp      = rst_n && (state == CHECK) && req && hit_any;
    assign bus.d_miss        = rst_n && req && ((state != CHECK) || !hit_any);
    assign bus.mem_rdata_cpu = hit_line[{word, 5'b00000} +: 32];

    // NOTE: line data and tags have no reset; valid bits gate every use, and leaving the arrays unreset keeps them in plain RAM.
    always_ff @(posedge clk) begin
        if (bus.mem_resp && bus.mem_write) begin
            data_arr[idx][hit_way] <= merge_word(hit_line, word, bus.mem_byte_enable_cpu, bus.mem_wdata_cpu);
        end else if (state == FILL && bus.pmem_resp) begin
            data_arr[miss_idx][miss_way] <= bus.pmem_rdata;
            tag_arr[miss_idx][miss_way]  <= miss_tag;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= CHECK;
            bus.pmem_read  <= 1'b0;
            bus.pmem_write <= 1'b0;
            hit_count      <= '0;
            miss_count     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            case (state)
                CHECK: begin
                    if (req && hit_any) begin
                        plru_arr[idx] <= plru_touch(plru_arr[idx], int'(hit_way));
                        if (bus.mem_write) dirty_arr[idx][hit_way] <= 1'b1;
                        if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
                    end else if (req) begin
                        miss_idx <= idx;
                        miss_tag <= tag;
                        miss_way <= victim;
                        if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
                        if (valid_arr[idx][victim] && dirty_arr[idx][victim]) begin
                            state            <= WRITEBACK;
                            bus.pmem_write   <= 1'b1;
                            bus.pmem_address <= {tag_arr[idx][victim], idx, 5'b00000};
                            bus.pmem_wdata   <= data_arr[idx][victim];
                        end else begin
                            state            <= FILL;
                            bus.pmem_read    <= 1'b1;
                            bus.pmem_address <= {tag, idx, 5'b00000};
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        state            <= FILL;
                        bus.pmem_write   <= 1'b0;
                        bus.pmem_read    <= 1'b1;
                        bus.pmem_address <= {miss_tag, miss_idx, 5'b00000};
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        state                        <= CHECK;
                        bus.pmem_read                <= 1'b0;
                        valid_arr[miss_idx][miss_way] <= 1'b1;
                        dirty_arr[miss_idx][miss_way] <= 1'b0;
                    end
                end
                default: state <= CHECK;
            endcase
        end
    end
endmodule

// File: tb/tb_param_cache.sv
// Self-checking bench for param_cache: directed vector table, reset/drop corner sequences,
// and randomized traffic compared against a golden memory image plus an LRU cache-occupancy model.
module tb_param_cache;
    localparam int LAT = 3;
    localparam int NV  = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    param_cache_if bus ();

    param_cache #(.S_INDEX(3), .WAYS(2), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] data;
    } wb_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_cyc;
        logic        wb_en;
        logic [31:0] wb_addr;
    } vec_t;

    logic [31:0] mem_w  [logic [31:0]];
    logic [31:0] gold_w [logic [31:0]];
    wb_t         wb_q[$];
    logic [31:0] fill_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return ((a & 32'hFFFF_FFFC) * 32'd2654435761) ^ 32'h1357_2468;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_w.exists(a) ? mem_w[a] : init_word(a);
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        return gold_w.exists(a) ? gold_w[a] : mem_word(a);
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word(la + 32'(4 * w));
        return l;
    endfunction

    function automatic logic [255:0] gold_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = gold_word(la + 32'(4 * w));
        return l;
    endfunction

    // Backing memory: answers a held request after LAT sampled cycles; forgets it under reset.
    initial begin
        int cnt;
        cnt = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (!rst_n || !(bus.pmem_read || bus.pmem_write)) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == LAT) begin
                    cnt = 0;
                    check("pmem_exclusive", bus.pmem_read & bus.pmem_write, 1'b0);
                    if (bus.pmem_write) begin
                        for (int w = 0; w < 8; w++)
                            mem_w[bus.pmem_address + 32'(4 * w)] = bus.pmem_wdata[32*w +: 32];
                        wb_q.push_back('{bus.pmem_address, bus.pmem_wdata});
                    end else begin
                        bus.pmem_rdata = mem_line(bus.pmem_address);
                        fill_q.push_back(bus.pmem_address);
                    end
                    bus.pmem_resp = 1'b1;
                end
            end
        end
    end

    // Caller is just past a rising edge; returns just past the edge that completed the request.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rdata, output int cyc, output logic dm);
        wb_q.delete();
        fill_q.delete();
        bus.mem_read = rd;
        bus.mem_write = wr;
        bus.mem_address = a;
        bus.mem_byte_enable_cpu = be;
        bus.mem_wdata_cpu = wd;
        cyc = 0;
        rdata = '0;
        dm = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc == 0) dm = bus.d_miss;
            if (bus.mem_resp) begin
                rdata = bus.mem_rdata_cpu;
                break;
            end
            cyc++;
            if (cyc >= 60) begin
                fail_now("req_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mem_resp", bus.mem_resp, 1'b0);
        check("rst_pmem_read", bus.pmem_read, 1'b0);
        check("rst_pmem_write", bus.pmem_write, 1'b0);
        check("rst_d_miss", bus.d_miss, 1'b0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_pmem_read(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pmem_read && n < 20);
        if (!bus.pmem_read) fail_now(name);
    endtask

    vec_t vecs[NV];

    // Random-phase occupancy model: per set/way tag, valid, dirty and time of last hit.
    int  m_tag   [8][2];
    bit  m_valid [8][2];
    bit  m_dirty [8][2];
    int  m_age   [8][2];

    initial begin
        logic [31:0] rdata;
        logic [31:0] w44;
        logic [31:0] exp;
        logic        dm;
        logic        seen;
        int          cyc;
        int          n;
        int          hits;
        int          misses;
        int          now;

        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_address = '0;
        bus.mem_byte_enable_cpu = '0;
        bus.mem_wdata_cpu = '0;

        w44 = init_word(32'h44);
        vecs[0]  = '{1, 0, 32'h040, 4'hF, 32'h0, init_word(32'h040), 4, 0, 32'h0};
        vecs[1]  = '{0, 1, 32'h044, 4'b0011, 32'hDEAD_BEEF, 32'h0, 0, 0, 32'h0};
        vecs[2]  = '{1, 0, 32'h044, 4'hF, 32'h0, {w44[31:16], 16'hBEEF}, 0, 0, 32'h0};
        vecs[3]  = '{1, 1, 32'h048, 4'hF, 32'h1122_3344, 32'h0, 0, 0, 32'h0};
        vecs[4]  = '{1, 0, 32'h048, 4'hF, 32'h0, 32'h1122_3344, 0, 0, 32'h0};
        vecs[5]  = '{0, 1, 32'h000, 4'hF, 32'hA0A0_A0A0, 32'h0, 4, 0, 32'h0};
        vecs[6]  = '{1, 0, 32'h100, 4'hF, 32'h0, init_word(32'h100), 4, 0, 32'h0};
        vecs[7]  = '{1, 0, 32'h100, 4'hF, 32'h0, init_word(32'h100), 0, 0, 32'h0};
        vecs[8]  = '{1, 0, 32'h200, 4'hF, 32'h0, init_word(32'h200), 2*LAT+1, 1, 32'h000};
        vecs[9]  = '{1, 0, 32'h000, 4'hF, 32'h0, 32'hA0A0_A0A0, 4, 0, 32'h0};
        vecs[10] = '{1, 0, 32'h104, 4'hF, 32'h0, init_word(32'h104), 4, 0, 32'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("init_rst_mem_resp", bus.mem_resp, 1'b0);
        check("init_rst_pmem_read", bus.pmem_read, 1'b0);
        check("init_rst_pmem_write", bus.pmem_write, 1'b0);
        check("init_rst_hit_count", hit_count, 32'd0);
        check("init_rst_miss_count", miss_count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, rdata, cyc, dm);
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
            check($sformatf("v%0d_d_miss", i), dm, vecs[i].exp_cyc != 0);
            if (vecs[i].rd && !vecs[i].wr) check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rd);
            check($sformatf("v%0d_fills", i), fill_q.size(), vecs[i].exp_cyc != 0);
            if (fill_q.size() > 0) check($sformatf("v%0d_fill_addr", i), fill_q[0], {vecs[i].addr[31:5], 5'b0});
            check($sformatf("v%0d_wbs", i), wb_q.size(), vecs[i].wb_en);
            if (wb_q.size() > 0) check($sformatf("v%0d_wb_addr", i), wb_q[0].addr, vecs[i].wb_addr);
        end
        check("tbl_hit_count", hit_count, 32'd11);
        check("tbl_miss_count", miss_count, 32'd6);

        // Reset during FILL abandons the fill; the line must still miss afterwards.
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h080;
        wait_pmem_read("rstfill_wait");
        check("rstfill_d_miss", bus.d_miss, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.mem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstfill_pmem_read", bus.pmem_read, 1'b0);
        check("rstfill_hit_count", hit_count, 32'd0);
        check("rstfill_miss_count", miss_count, 32'd0);
        check("rstfill_d_miss_rst", bus.d_miss, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_req(1, 0, 32'h080, 4'hF, 32'h0, rdata, cyc, dm);
        check("rstfill_reread_cycles", cyc, LAT + 1);
        check("rstfill_reread_data", rdata, init_word(32'h080));

        // Request dropped mid-FILL: no response, but the line lands in the latched set.
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h0C0;
        wait_pmem_read("drop_wait");
        check("drop_d_miss_held", bus.d_miss, 1'b1);
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0;
        bus.mem_address = 32'h0;
        seen = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            seen |= bus.mem_resp;
            n++;
        end while ((bus.pmem_read || n < 3) && n < 20);
        check("drop_no_resp", seen, 1'b0);
        check("drop_fill_done", bus.pmem_read, 1'b0);
        check("drop_d_miss_idle", bus.d_miss, 1'b0);
        @(posedge clk);
        #1;
        do_req(1, 0, 32'h0C0, 4'hF, 32'h0, rdata, cyc, dm);
        check("drop_reissue_cycles", cyc, 0);
        check("drop_reissue_data", rdata, init_word(32'h0C0));
        check("drop_hit_count", hit_count, 32'd2);
        check("drop_miss_count", miss_count, 32'd2);

        // Randomized traffic over two conflicting sets and four tags.
        do_reset();
        gold_w.delete();
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_age[s][w] = 0;
                m_tag[s][w] = 0;
            end
        hits = 0;
        misses = 0;
        now = 0;
        for (int op = 0; op < 200; op++) begin
            int          s;
            int          tg;
            int          kind;
            int          hw;
            int          v;
            int          exp_cyc;
            bit          exp_wb;
            logic [31:0] a;
            logic [31:0] wd;
            logic [3:0]  be;
            logic [31:0] wb_addr;
            logic [255:0] wb_data;
            logic        rd;
            logic        wr;

            s    = $urandom_range(0, 1);
            tg   = $urandom_range(0, 3);
            a    = 32'((tg << 8) | (s << 5) | ($urandom_range(0, 7) << 2));
            kind = $urandom_range(0, 3);
            rd   = (kind != 2);
            wr   = (kind >= 2);
            be   = 4'($urandom_range(1, 15));
            wd   = $urandom;

            hw = -1;
            for (int w = 0; w < 2; w++)
                if (m_valid[s][w] && m_tag[s][w] == tg) hw = w;
            exp_wb = 0;
            wb_addr = '0;
            wb_data = '0;
            if (hw >= 0) begin
                exp_cyc = 0;
            end else begin
                v = -1;
                for (int w = 0; w < 2; w++)
                    if (!m_valid[s][w] && v < 0) v = w;
                if (v < 0) v = (m_age[s][1] < m_age[s][0]) ? 1 : 0;
                exp_wb = m_valid[s][v] && m_dirty[s][v];
                if (exp_wb) begin
                    wb_addr = 32'((m_tag[s][v] << 8) | (s << 5));
                    wb_data = gold_line(wb_addr);
                end
                exp_cyc = exp_wb ? 2 * LAT + 1 : LAT + 1;
                m_valid[s][v] = 1;
                m_dirty[s][v] = 0;
                m_tag[s][v] = tg;
                hw = v;
                misses++;
            end
            now++;
            m_age[s][hw] = now;
            hits++;

            do_req(rd, wr, a, be, wd, rdata, cyc, dm);
            check($sformatf("r%0d_cycles", op), cyc, exp_cyc);
            if (!wr) check($sformatf("r%0d_rdata@%0h", op, a), rdata, gold_word(a));
            check($sformatf("r%0d_fills", op), fill_q.size(), exp_cyc != 0);
            if (fill_q.size() > 0) check($sformatf("r%0d_fill_addr", op), fill_q[0], {a[31:5], 5'b0});
            check($sformatf("r%0d_wbs", op), wb_q.size(), exp_wb);
            if (exp_wb && wb_q.size() > 0) begin
                check($sformatf("r%0d_wb_addr", op), wb_q[0].addr, wb_addr);
                check($sformatf("r%0d_wb_data", op), wb_q[0].data, wb_data);
            end

            if (wr) begin
                exp = gold_word(a);
                for (int b = 0; b < 4; b++)
                    if (be[b]) exp[8*b +: 8] = wd[8*b +: 8];
                gold_w[a] = exp;
                m_dirty[s][hw] = 1;
            end
        end
        check("rand_hit_count", hit_count, 32'(hits));
        check("rand_miss_count", miss_count, 32'(misses));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/param_cache.md
PARAM_CACHE -- requirements
Module: param_cache

Interface
REQ-001 SHALL have parameter S_INDEX, default 3, meaning set-index bits (2**S_INDEX sets).
REQ-002 SHALL have parameter WAYS, default 2, meaning associativity; legal values 1, 2, 4, 8.
REQ-003 SHALL have parameter CNT_W, default 32, meaning width of each statistics counter.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port mem_read  input  1  CPU read request, held until mem_resp.
REQ-007 SHALL have port mem_write  input  1  CPU write request, held until mem_resp.
REQ-008 SHALL have port mem_byte_enable_cpu  input  4  byte lanes of the 32-bit write.
REQ-009 SHALL have port mem_address  input  32  byte address; [4:0] offset, [5+S_INDEX-1:5] index, rest tag.
REQ-010 SHALL have port mem_wdata_cpu  input  32  CPU write data.
REQ-011 SHALL have port mem_resp  output  1  one-cycle completion strobe.
REQ-012 SHALL have port mem_rdata_cpu  output  32  selected word of hit line.
REQ-013 SHALL have port d_miss  output  1  request present and not hitting.
REQ-014 SHALL have port pmem_resp  input  1  memory completion strobe.
REQ-015 SHALL have port pmem_rdata  input  256  fill line.
REQ-016 SHALL have port pmem_address  output  32  line address, [4:0]=0.
REQ-017 SHALL have port pmem_wdata  output  256  writeback line.
REQ-018 SHALL have ports pmem_read, pmem_write  output  1 each  memory requests, held until pmem_resp.
REQ-019 SHALL have ports hit_count, miss_count  output  CNT_W each  statistics counters.

Function
REQ-020 SHALL be write-back, write-allocate, WAYS-way set-associative, 256-bit lines, tree-PLRU (WAYS-1 bits per set; none when WAYS=1).
REQ-021 SHALL implement FSM states CHECK, WRITEBACK, FILL; reset state CHECK.
REQ-022 In CHECK, hit (valid and tag match in any way) SHALL assert mem_resp combinationally in the same cycle; zero added latency.
REQ-023 Write hit SHALL merge mem_wdata_cpu into word mem_address[4:2] per byte enable and set dirty, on that same edge.
REQ-024 Any hit SHALL update PLRU of the set to mark the hit way most recent.
REQ-025 Victim on miss SHALL be lowest-index invalid way, else the PLRU way.
REQ-026 CHECK miss: victim dirty -> WRITEBACK, else -> FILL.
REQ-027 WRITEBACK SHALL drive pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line; on pmem_resp -> FILL.
REQ-028 FILL SHALL drive pmem_read=1, pmem_address={req tag, index, 5'b0}; on pmem_resp load line, set valid, clear dirty, write tag, -> CHECK.
REQ-029 After FILL the request SHALL hit in CHECK the next cycle (miss latency = memory cycles + 1).
REQ-030 pmem_read and pmem_write SHALL never both be 1; pmem_resp SHALL be ignored in CHECK.
REQ-031 d_miss SHALL equal (mem_read|mem_write) & ~hit, forced 1 in WRITEBACK/FILL while request held.
REQ-032 mem_read and mem_write both high SHALL be treated as write.
REQ-033 Request dropped mid-miss: transaction SHALL complete, no mem_resp issued.
REQ-034 hit_count SHALL increment on each mem_resp cycle; miss_count on each CHECK->WRITEBACK/FILL transition; both saturate at all-ones.

Reset
REQ-035 rst_n=0 at an edge SHALL clear all valid, dirty, PLRU bits and counters, force CHECK, from any state.
REQ-036 During and after reset mem_resp, pmem_read, pmem_write, d_miss SHALL be 0 (absent request); data/tag arrays need no reset.
REQ-037 Reset mid-WRITEBACK/FILL SHALL drop pmem requests the following cycle; memory abandons the transaction.

Verification
REQ-038 Cold read 0x0000_0040, memory returns line after 3 cycles -> one FILL at 0x40, mem_resp 1 cycle after pmem_resp, miss_count=1, hit_count=1.
REQ-039 Write 0xDEADBEEF be=4'b0011 to 0x44 after fill -> same-cycle mem_resp; read 0x44 returns old[31:16] with 0xBEEF low.
REQ-040 WAYS=2: fill tags A,B in set 0 (dirty A), touch B, miss tag C -> WRITEBACK of A at {A,0,5'b0} then FILL C.
REQ-041 Assert rst_n=0 during FILL -> pmem_read=0 next cycle, counters 0, re-read of same address misses.
REQ-042 Drop mem_read during FILL -> no mem_resp; re-issue hits immediately, hit_count +1, miss_count unchanged.
